// File: rtl/aes_pkg.sv
// Shared AES constants and types for the AES-256 key schedule.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    typedef logic [31:0] word_t;

    localparam int unsigned NK = 8;
    localparam int unsigned NR = 14;
    localparam int unsigned NW = 60;

    // Entry 0 is unused; round constants are indexed by i/8 = 1..7.
    localparam logic [7:0] RCON [0:7] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

endpackage

// File: rtl/aes256_key_sched_if.sv
// Key load and round-key read bus of the AES-256 key schedule.
interface aes256_key_sched_if;

    logic         key_v_i;
    logic [255:0] key_i;
    logic         key_ready_o;
    logic         busy_o;
    logic         done_o;
    logic         rk_rd_v_i;
    logic [3:0]   rk_idx_i;
    logic         rk_v_o;
    logic [127:0] rk_o;

    modport slave (
        input  key_v_i, key_i, rk_rd_v_i, rk_idx_i,
        output key_ready_o, busy_o, done_o, rk_v_o, rk_o
    );

    modport master (
        output key_v_i, key_i, rk_rd_v_i, rk_idx_i,
        input  key_ready_o, busy_o, done_o, rk_v_o, rk_o
    );

endinterface

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box substitution of a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  word_t din_i,
    output word_t dout_o
);

    rom_sbox u_sbox3 (.addr_i(din_i[31:24]), .data_o(dout_o[31:24]));
    rom_sbox u_sbox2 (.addr_i(din_i[23:16]), .data_o(dout_o[23:16]));
    rom_sbox u_sbox1 (.addr_i(din_i[15:8]),  .data_o(dout_o[15:8]));
    rom_sbox u_sbox0 (.addr_i(din_i[7:0]),   .data_o(dout_o[7:0]));

endmodule

// File: rtl/rom_sbox.sv
// AES forward S-box as a combinational 256x8 lookup.
module rom_sbox (
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset is (255-addr)*8.
    assign data_o = SBOX[{~addr_i, 3'b000} +: 8];

endmodule

// File: rtl/aes256_key_sched.sv
// AES-256 key expansion: one word per cycle into a 60-word array,
// with registered 128-bit round-key reads once the schedule is complete.
module aes256_key_sched
    import aes_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_n_i,
    aes256_key_sched_if.slave bus
);

    state_t       state_q, state_d;
    logic [5:0]   i_q, i_d;
    word_t        w_q [0:NW-1];
    logic         load_en, wr_en;
    word_t        prev_w, sub_in, sub_out, temp_w, new_w;
    logic [5:0]   rd_base;
    logic         rd_acc;
    logic [127:0] rk_q, rk_d;
    logic         rk_v_q, rk_v_d;

    assign bus.key_ready_o = (state_q != EXPAND);
    assign bus.busy_o      = (state_q == EXPAND);
    assign bus.done_o      = (state_q == DONE);
    assign bus.rk_v_o      = rk_v_q;
    assign bus.rk_o        = rk_q;

    // Control state, word counter and read-port registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            i_q     <= 6'(NK);
            rk_q    <= '0;
            rk_v_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            rk_q    <= rk_d;
            rk_v_q  <= rk_v_d;
        end
    end

    // Next state: accept a key in IDLE/DONE, step one word per cycle in EXPAND.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        load_en = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.key_v_i) begin
                    load_en = 1'b1;
                    i_d     = 6'(NK);
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr_en = 1'b1;
                if (i_q == 6'(NW - 1)) begin
                    state_d = DONE;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One S-box bank serves both the RotWord and plain SubWord steps.
    assign prev_w = w_q[i_q - 6'd1];
    assign sub_in = (i_q[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    aes_subword u_subword (
        .din_i  (sub_in),
        .dout_o (sub_out)
    );

    // Next schedule word w[i] from w[i-1] and w[i-8].
    always_comb begin
        temp_w = prev_w;
        if (i_q[2:0] == 3'd0) begin
            temp_w = sub_out ^ {RCON[i_q[5:3]], 24'h0};
        end else if (i_q[2:0] == 3'd4) begin
            temp_w = sub_out;
        end
        new_w = w_q[i_q - 6'(NK)] ^ temp_w;
    end

    // Word array: no reset needed, it is only readable once DONE is reached.
    always_ff @(posedge clk_i) begin
        if (load_en) begin
            for (int unsigned k = 0; k < NK; k++) begin
                w_q[k] <= bus.key_i[255 - 32*k -: 32];
            end
        end else if (wr_en) begin
            w_q[i_q] <= new_w;
        end
    end

    assign rd_base = {bus.rk_idx_i, 2'b00};
    assign rd_acc  = bus.rk_rd_v_i && (state_q == DONE);

    // Round-key read: sampled from the array before any same-edge key load.
    always_comb begin
        rk_v_d = rd_acc;
        rk_d   = rk_q;
        if (rd_acc) begin
            if (bus.rk_idx_i == 4'hF) begin
                rk_d = '0;
            end else begin
                rk_d = {w_q[rd_base], w_q[rd_base | 6'd1],
                        w_q[rd_base | 6'd2], w_q[rd_base | 6'd3]};
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_sched.sv
// Self-checking bench for aes256_key_sched: cycle-level behavioural model
// with an arithmetic (GF(2^8)) S-box, plus FIPS-197 literal expectations.
module tb_aes256_key_sched;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_B =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    aes256_key_sched_if bus ();

    aes256_key_sched dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int k = 0; k < 8; k++) w[k] = key[255 - 32*k -: 32];
        for (int k = 8; k < 60; k++) begin
            t = w[k-1];
            if (k % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (k % 8 == 4) begin
                t = subw(t);
            end
            w[k] = w[k-8] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    logic         m_valid = 1'b0;
    logic         m_busy, m_done, m_rkv;
    int           m_cnt;
    logic [255:0] m_key;
    logic [127:0] m_rk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_rkv   <= 1'b0;
            m_rk    <= '0;
            m_cnt   <= 0;
        end else begin
            m_rkv <= bus.rk_rd_v_i && m_done;
            if (bus.rk_rd_v_i && m_done)
                m_rk <= (bus.rk_idx_i == 4'hF) ? 128'h0 : round_key(m_key, int'(bus.rk_idx_i));
            if (m_busy) begin
                if (m_cnt == 51) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_cnt <= m_cnt + 1;
            end else if (bus.key_v_i) begin
                m_key  <= bus.key_i;
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_cnt  <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("key_ready", 128'(bus.key_ready_o), 128'(!m_busy));
            check("busy",      128'(bus.busy_o),      128'(m_busy));
            check("done",      128'(bus.done_o),      128'(m_done));
            check("rk_v",      128'(bus.rk_v_o),      128'(m_rkv));
            check("rk",        bus.rk_o,              m_rk);
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_key(input logic [255:0] k);
        @(negedge clk);
        bus.key_v_i = 1'b1;
        bus.key_i   = k;
        @(posedge clk);
        @(negedge clk);
        bus.key_v_i = 1'b0;
    endtask

    // Called just after the accepting edge's following negedge; expects 52 edges.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                n = c;
                break;
            end
            check("rkv_expand", 128'(bus.rk_v_o), 128'h0);
        end
        if (n == 0) n = 61;
        check(name, 128'(n), 128'd52);
    endtask

    task automatic do_read(input logic [3:0] r, input logic [127:0] exp, input string name);
        @(negedge clk);
        bus.rk_rd_v_i = 1'b1;
        bus.rk_idx_i  = r;
        @(posedge clk);
        #1;
        check({name, "_v"}, 128'(bus.rk_v_o), 128'h1);
        check(name, bus.rk_o, exp);
        @(negedge clk);
        bus.rk_rd_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.key_v_i   = 1'b0;
        bus.key_i     = '0;
        bus.rk_rd_v_i = 1'b0;
        bus.rk_idx_i  = 4'h0;

        // pin the model against FIPS-197 A.3
        check("model_rk2",  round_key(KEY_A3, 2),  A3_RK2);
        check("model_rk14", round_key(KEY_A3, 14), A3_RK14);

        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ready", 128'(bus.key_ready_o), 128'h1);
        check("rst_busy",      128'(bus.busy_o),      128'h0);
        check("rst_done",      128'(bus.done_o),      128'h0);
        check("rst_rk_v",      128'(bus.rk_v_o),      128'h0);
        check("rst_rk",        bus.rk_o,              128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // A.3 key with reads requested throughout the expansion
        @(negedge clk);
        bus.rk_rd_v_i = 1'b1;
        bus.rk_idx_i  = 4'd3;
        load_key(KEY_A3);
        wait_done("latency_a3");
        @(negedge clk);
        bus.rk_rd_v_i = 1'b0;

        do_read(4'd2,  A3_RK2,  "a3_rk2");
        do_read(4'd14, A3_RK14, "a3_rk14");
        do_read(4'd0,  KEY_A3[255:128], "a3_rk0");
        do_read(4'd1,  KEY_A3[127:0],   "a3_rk1");
        do_read(4'd15, 128'h0,          "a3_rk15");

        // new key held valid through the whole expansion is ignored
        @(negedge clk);
        bus.key_v_i = 1'b1;
        bus.key_i   = KEY_A3;
        @(posedge clk);
        @(negedge clk);
        bus.key_i = KEY_B;
        wait_done("latency_hold");
        @(negedge clk);
        bus.key_v_i = 1'b0;
        do_read(4'd14, A3_RK14, "hold_rk14");

        // key and read on the same edge in DONE
        @(negedge clk);
        bus.key_v_i   = 1'b1;
        bus.key_i     = KEY_B;
        bus.rk_rd_v_i = 1'b1;
        bus.rk_idx_i  = 4'd14;
        @(posedge clk);
        #1;
        check("same_edge_rk",   bus.rk_o,              A3_RK14);
        check("same_edge_done", 128'(bus.done_o),      128'h0);
        check("same_edge_busy", 128'(bus.busy_o),      128'h1);
        @(negedge clk);
        bus.key_v_i   = 1'b0;
        bus.rk_rd_v_i = 1'b0;
        wait_done("latency_b");
        do_read(4'd0, KEY_B[255:128], "b_rk0");
        do_read(4'd7, round_key(KEY_B, 7), "b_rk7");

        // asynchronous reset in the middle of an expansion
        load_key(KEY_A3);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      128'(bus.busy_o),      128'h0);
        check("arst_done",      128'(bus.done_o),      128'h0);
        check("arst_rk_v",      128'(bus.rk_v_o),      128'h0);
        check("arst_rk",        bus.rk_o,              128'h0);
        check("arst_key_ready", 128'(bus.key_ready_o), 128'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_stays_idle", 128'(bus.done_o), 128'h0);
        load_key(KEY_A3);
        wait_done("latency_after_rst");
        do_read(4'd14, A3_RK14, "rst_rk14");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
